multi_trigger_gen: RTL and testbench

MULTI_TRIGGER_GEN -- requirements
Module: multi_trigger_gen

---
 rtl/trigger_gen_pkg.sv | 15 +
 rtl/multi_trigger_gen_if.sv | 40 ++++
 rtl/trigger_channel.sv | 166 ++++++++++++++++
 rtl/multi_trigger_gen.sv | 57 +++++
 tb/tb_multi_trigger_gen.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_gen_pkg.sv
// Shared definitions for the multi-channel trigger generator.
// Holds the per-channel FSM state encoding and the default channel count / counter width.
// No ports; imported by the interface, the channel and the top.
package trigger_gen_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2
  } ch_state_t;

endpackage

// File: rtl/multi_trigger_gen_if.sv
// Bundle of per-channel control inputs and trigger/status outputs for multi_trigger_gen.
// master: the controller driving start/stop/config and observing outputs; slave: the generator.
// Optional opTrigCount exists only when MULTI_TRIGGER_GEN_COUNT_EN is defined.
interface multi_trigger_gen_if
  import trigger_gen_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [N_CH-1:0]       ipStart;
  logic [N_CH-1:0]       ipStop;
  logic [N_CH*WIDTH-1:0] ipPeriod;
  logic [N_CH*WIDTH-1:0] ipPhase;
  logic [N_CH*WIDTH-1:0] ipPulseWidth;
  logic [N_CH*WIDTH-1:0] ipBurst;
  logic [N_CH-1:0]       opTrigger;
  logic [N_CH-1:0]       opBusy;
  logic [N_CH-1:0]       opDone;
`ifdef MULTI_TRIGGER_GEN_COUNT_EN
  logic [N_CH*WIDTH-1:0] opTrigCount;
`endif

  modport master (
    output ipStart, ipStop, ipPeriod, ipPhase, ipPulseWidth, ipBurst,
    input  opTrigger, opBusy, opDone
`ifdef MULTI_TRIGGER_GEN_COUNT_EN
    , input opTrigCount
`endif
  );

  modport slave (
    input  ipStart, ipStop, ipPeriod, ipPhase, ipPulseWidth, ipBurst,
    output opTrigger, opBusy, opDone
`ifdef MULTI_TRIGGER_GEN_COUNT_EN
    , output opTrigCount
`endif
  );

endinterface

// File: rtl/trigger_channel.sv
// One trigger channel: IDLE -> (DELAY) -> RUN periodic pulse train, optional finite burst.
// Ports: clk/rst (rst already registered, sync active-high), start/stop pulses, period/phase/
// pulse-width/burst config, registered trig/done, busy; trig_cnt with MULTI_TRIGGER_GEN_COUNT_EN.
module trigger_channel
  import trigger_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] phase_in,
  input  logic [WIDTH-1:0] pw_in,
  input  logic [WIDTH-1:0] burst_in,
  output logic             trig,
  output logic             busy,
  output logic             done
`ifdef MULTI_TRIGGER_GEN_COUNT_EN
  ,
  output logic [WIDTH-1:0] trig_cnt
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  ch_state_t        state_q, state_d;
  logic [WIDTH-1:0] dly_q, dly_d;        // cycles spent in DELAY, 1-based
  logic [WIDTH-1:0] pos_q, pos_d;        // position inside current period, 1..period
  logic [WIDTH-1:0] nper_q, nper_d;      // completed periods of the burst
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] pw_q, pw_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] burst_q, burst_d;
  logic             trig_q, trig_d;
  logic             done_q, done_d;

  // Zero period/width behave as one so the counter always advances and the
  // first cycle of every period is high.
  logic [WIDTH-1:0] period_eff, pw_eff;
  assign period_eff = (period_q == '0) ? ONE : period_q;
  assign pw_eff     = (pw_q == '0) ? ONE : pw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dly_q    <= '0;
      pos_q    <= '0;
      nper_q   <= '0;
      period_q <= '0;
      pw_q     <= '0;
      phase_q  <= '0;
      burst_q  <= '0;
      trig_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      pos_q    <= pos_d;
      nper_q   <= nper_d;
      period_q <= period_d;
      pw_q     <= pw_d;
      phase_q  <= phase_d;
      burst_q  <= burst_d;
      trig_q   <= trig_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic. Trigger and done are computed for the
  // coming cycle so the outputs leave a register.
  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    pos_d    = pos_q;
    nper_d   = nper_q;
    period_d = period_q;
    pw_d     = pw_q;
    phase_d  = phase_q;
    burst_d  = burst_q;
    trig_d   = 1'b0;
    done_d   = 1'b0;

    if (stop) begin
      // Stop dominates a simultaneous start; harmless when already idle.
      state_d = IDLE;
      dly_d   = '0;
      pos_d   = '0;
      nper_d  = '0;
    end else if (start) begin
      // Restart from any state, abandoning a running burst without done.
      period_d = period_in;
      pw_d     = pw_in;
      phase_d  = phase_in;
      burst_d  = burst_in;
      dly_d    = '0;
      pos_d    = '0;
      nper_d   = '0;
      if (phase_in != '0) begin
        state_d = DELAY;
        dly_d   = ONE;
      end else begin
        state_d = RUN;
        pos_d   = ONE;
        trig_d  = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: ;
        DELAY: begin
          if (dly_q >= phase_q) begin
            state_d = RUN;
            dly_d   = '0;
            pos_d   = ONE;
            trig_d  = 1'b1;
          end else begin
            dly_d = dly_q + ONE;
          end
        end
        RUN: begin
          if (pos_q >= period_eff) begin
            if ((burst_q != '0) && (nper_q >= burst_q - ONE)) begin
              state_d = IDLE;
              pos_d   = '0;
              nper_d  = '0;
              done_d  = 1'b1;
            end else begin
              // Period boundary: the only point where new period/width take effect.
              pos_d    = ONE;
              trig_d   = 1'b1;
              period_d = period_in;
              pw_d     = pw_in;
              if (burst_q != '0) nper_d = nper_q + ONE;
            end
          end else begin
            pos_d  = pos_q + ONE;
            trig_d = ((pos_q + ONE) <= pw_eff);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign trig = trig_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

`ifdef MULTI_TRIGGER_GEN_COUNT_EN
  // Counts edges in step with the trigger register; a restart clears the
  // count but still counts an edge produced by that same start.
  logic [WIDTH-1:0] cnt_q;
  logic             rise;
  assign rise = trig_d & ~trig_q;

  always_ff @(posedge clk) begin
    if (rst)        cnt_q <= '0;
    else if (start) cnt_q <= rise ? ONE : '0;
    else if (rise)  cnt_q <= cnt_q + ONE;
  end

  assign trig_cnt = cnt_q;
`endif

endmodule

// File: rtl/multi_trigger_gen.sv
// N_CH independent periodic trigger generators with phase delay, pulse width and burst count.
// Ports: ipClk, Reset (sync active-high, registered once before use -> two-cycle latency),
// bus (slave modport: start/stop/config in, opTrigger/opBusy/opDone out; opTrigCount with MULTI_TRIGGER_GEN_COUNT_EN).
module multi_trigger_gen
  import trigger_gen_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               ipClk,
  input  logic               Reset,
  multi_trigger_gen_if.slave bus
);

  // Reset is retimed once so every channel sees a clean, flop-driven reset.
  logic rst_q;
  always_ff @(posedge ipClk) begin
    rst_q <= Reset;
  end

  logic [N_CH-1:0] trig;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] done;
`ifdef MULTI_TRIGGER_GEN_COUNT_EN
  logic [N_CH*WIDTH-1:0] cnt;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    trigger_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk       (ipClk),
      .rst       (rst_q),
      .start     (bus.ipStart[i]),
      .stop      (bus.ipStop[i]),
      .period_in (bus.ipPeriod[i*WIDTH +: WIDTH]),
      .phase_in  (bus.ipPhase[i*WIDTH +: WIDTH]),
      .pw_in     (bus.ipPulseWidth[i*WIDTH +: WIDTH]),
      .burst_in  (bus.ipBurst[i*WIDTH +: WIDTH]),
      .trig      (trig[i]),
      .busy      (busy[i]),
      .done      (done[i])
`ifdef MULTI_TRIGGER_GEN_COUNT_EN
      ,
      .trig_cnt  (cnt[i*WIDTH +: WIDTH])
`endif
    );
  end

  assign bus.opTrigger = trig;
  assign bus.opBusy    = busy;
  assign bus.opDone    = done;
`ifdef MULTI_TRIGGER_GEN_COUNT_EN
  assign bus.opTrigCount = cnt;
`endif

endmodule

// File: tb/tb_multi_trigger_gen.sv
// Self-checking bench for multi_trigger_gen: vector table for a burst, then directed sequences.
// Cycle t is the interval after the t-th clock edge following the start-driving cycle (t=0).
// Trigger-count checks are compiled in only with MULTI_TRIGGER_GEN_COUNT_EN.
module tb_multi_trigger_gen;

  localparam int N_CH = 4;
  localparam int W    = 32;

  logic ipClk = 1'b0;
  logic Reset;
  always #5 ipClk = ~ipClk;

  multi_trigger_gen_if #(.N_CH(N_CH), .WIDTH(W)) bus ();

  multi_trigger_gen #(.N_CH(N_CH), .WIDTH(W)) dut (
    .ipClk (ipClk),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic start;
    logic trig;
    logic busy;
    logic done;
  } vec_t;

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ipClk);
    #1;
  endtask

  task automatic cfg(input int ch, input logic [W-1:0] per, input logic [W-1:0] ph,
                     input logic [W-1:0] pw, input logic [W-1:0] br);
    bus.ipPeriod[ch*W +: W]     = per;
    bus.ipPhase[ch*W +: W]      = ph;
    bus.ipPulseWidth[ch*W +: W] = pw;
    bus.ipBurst[ch*W +: W]      = br;
  endtask

  task automatic chk_all_zero(input string nm);
    for (int c = 0; c < N_CH; c++) begin
      chkb($sformatf("%s_trig%0d", nm, c), bus.opTrigger[c], 1'b0);
      chkb($sformatf("%s_busy%0d", nm, c), bus.opBusy[c], 1'b0);
      chkb($sformatf("%s_done%0d", nm, c), bus.opDone[c], 1'b0);
    end
  endtask

  initial begin
    vec_t tbl[18];
    logic e;
    logic e_prev;
    int   edges;

    // Burst of three 5-cycle periods, width 2, no phase, started at t=0.
    tbl[ 0] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[ 1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[ 2] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[ 3] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[ 4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[ 5] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[ 6] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[ 7] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[ 8] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[ 9] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0};

    bus.ipStart      = '0;
    bus.ipStop       = '0;
    bus.ipPeriod     = '0;
    bus.ipPhase      = '0;
    bus.ipPulseWidth = '0;
    bus.ipBurst      = '0;
    Reset            = 1'b1;
    repeat (4) tick();
    chk_all_zero("reset");
    Reset = 1'b0;
    repeat (3) tick();

    // ---- Table: ch0 burst ----
    cfg(0, 5, 0, 2, 3);
    for (int t = 0; t < 18; t++) begin
      chkb($sformatf("burst_t%0d_trig", t), bus.opTrigger[0], tbl[t].trig);
      chkb($sformatf("burst_t%0d_busy", t), bus.opBusy[0], tbl[t].busy);
      chkb($sformatf("burst_t%0d_done", t), bus.opDone[0], tbl[t].done);
      bus.ipStart[0] = tbl[t].start;
      tick();
    end
`ifdef MULTI_TRIGGER_GEN_COUNT_EN
    chkw("burst_count", bus.opTrigCount[0 +: W], 32'd3);
`endif

    // ---- ch1: phase 7, period 4, width 1, continuous, then stop ----
    cfg(1, 4, 7, 1, 0);
    bus.ipStart[1] = 1'b1;
    tick();
    bus.ipStart[1] = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      e = (t >= 8) && (((t - 8) % 4) == 0);
      chkb($sformatf("phase_t%0d_trig", t), bus.opTrigger[1], e);
      chkb($sformatf("phase_t%0d_busy", t), bus.opBusy[1], 1'b1);
      chkb($sformatf("phase_t%0d_done", t), bus.opDone[1], 1'b0);
      if (t == 20) bus.ipStop[1] = 1'b1;
      tick();
    end
    bus.ipStop[1] = 1'b0;
    chkb("stop_trig", bus.opTrigger[1], 1'b0);
    chkb("stop_busy", bus.opBusy[1], 1'b0);
    chkb("stop_done", bus.opDone[1], 1'b0);
    tick();
    chkb("stop_done_later", bus.opDone[1], 1'b0);

    // ---- ch0: period changes 10 -> 3 in the middle of a period ----
    cfg(0, 10, 0, 2, 0);
    bus.ipStart[0] = 1'b1;
    tick();
    bus.ipStart[0] = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      if (t <= 10) e = (t <= 2);
      else         e = (((t - 11) % 3) < 2);
      chkb($sformatf("perchg_t%0d_trig", t), bus.opTrigger[0], e);
      if (t == 4) bus.ipPeriod[0 +: W] = 32'd3;
      tick();
    end
    bus.ipStop[0] = 1'b1;
    tick();
    bus.ipStop[0] = 1'b0;
    chkb("perchg_stop_busy", bus.opBusy[0], 1'b0);

    // ---- ch2 period/width 0, ch3 width >= period: both constantly high ----
    cfg(2, 0, 0, 0, 0);
    cfg(3, 4, 0, 8, 0);
    bus.ipStart[2] = 1'b1;
    bus.ipStart[3] = 1'b1;
    tick();
    bus.ipStart[2] = 1'b0;
    bus.ipStart[3] = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      chkb($sformatf("zero_t%0d_trig2", t), bus.opTrigger[2], 1'b1);
      chkb($sformatf("wide_t%0d_trig3", t), bus.opTrigger[3], 1'b1);
      tick();
    end
    bus.ipStop[2] = 1'b1;
    bus.ipStop[3] = 1'b1;
    tick();
    bus.ipStop[2] = 1'b0;
    bus.ipStop[3] = 1'b0;
    chkb("wide_stop_trig3", bus.opTrigger[3], 1'b0);

    // ---- ch2 start+stop together while ch3 keeps running ----
    cfg(2, 3, 0, 1, 0);
    cfg(3, 4, 0, 2, 0);
    bus.ipStart[2] = 1'b1;
    bus.ipStart[3] = 1'b1;
    tick();
    bus.ipStart[2] = 1'b0;
    bus.ipStart[3] = 1'b0;
    e_prev = 1'b0;
    edges  = 0;
    for (int t = 1; t <= 12; t++) begin
      e = (((t - 1) % 4) < 2);
      if (e && !e_prev) edges++;
      e_prev = e;
      chkb($sformatf("indep_t%0d_trig3", t), bus.opTrigger[3], e);
      if (t < 6) chkb($sformatf("indep_t%0d_busy2", t), bus.opBusy[2], 1'b1);
      else begin
        chkb($sformatf("indep_t%0d_busy2", t), bus.opBusy[2], 1'b0);
        chkb($sformatf("indep_t%0d_trig2", t), bus.opTrigger[2], 1'b0);
        chkb($sformatf("indep_t%0d_done2", t), bus.opDone[2], 1'b0);
      end
      if (t == 5) begin
        bus.ipStart[2] = 1'b1;
        bus.ipStop[2]  = 1'b1;
      end else begin
        bus.ipStart[2] = 1'b0;
        bus.ipStop[2]  = 1'b0;
      end
`ifdef MULTI_TRIGGER_GEN_COUNT_EN
      if (t == 12) begin
        chkw("indep_count3", bus.opTrigCount[3*W +: W], W'(edges));
        chkw("indep_count2", bus.opTrigCount[2*W +: W], 32'd0);
      end
`endif
      tick();
    end
    bus.ipStop[3] = 1'b1;
    tick();
    bus.ipStop[3] = 1'b0;

    // ---- Reset in the middle of bursts on every channel ----
    for (int c = 0; c < N_CH; c++) cfg(c, 5, 0, 2, 3);
    bus.ipStart = '1;
    tick();
    bus.ipStart = '0;
    for (int t = 1; t <= 8; t++) begin
      for (int c = 0; c < N_CH; c++)
        chkb($sformatf("rstmid_t%0d_done%0d", t, c), bus.opDone[c], 1'b0);
      if (t == 6 || t == 7) begin
        chk_all_zero($sformatf("rstmid_t%0d", t));
`ifdef MULTI_TRIGGER_GEN_COUNT_EN
        chkw($sformatf("rstmid_t%0d_count0", t), bus.opTrigCount[0 +: W], 32'd0);
`endif
      end
      if (t == 4) Reset = 1'b1;
      if (t == 7) Reset = 1'b0;
      tick();
    end

    // ---- Restart after reset: single 2-cycle period on ch0 ----
    cfg(0, 2, 0, 1, 1);
    bus.ipStart[0] = 1'b1;
    tick();
    bus.ipStart[0] = 1'b0;
    chkb("restart_t1_trig", bus.opTrigger[0], 1'b1);
    chkb("restart_t1_busy", bus.opBusy[0], 1'b1);
    tick();
    chkb("restart_t2_trig", bus.opTrigger[0], 1'b0);
    chkb("restart_t2_done", bus.opDone[0], 1'b0);
    tick();
    chkb("restart_t3_done", bus.opDone[0], 1'b1);
    chkb("restart_t3_busy", bus.opBusy[0], 1'b0);
    tick();
    chkb("restart_t4_done", bus.opDone[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
